// File: rtl/instruction_encoder_if.sv
// ============================================================================
//  Module   : instruction_encoder_if
//  Brief    : Field-side handshake and memory write port of the instruction encoder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface instruction_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [7:0]        op_dk;
    logic [3:0]        op_s;
    logic [3:0]        s;
    logic              arp;
    logic [6:0]        dk;
    logic [15:0]       all;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, base_addr, finish, in_valid, fmt, op_dk, op_s, s, arp, dk, all, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
    );

    modport slave (
        input  start, base_addr, finish, in_valid, fmt, op_dk, op_s, s, arp, dk, all, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/instruction_encoder.sv
// ============================================================================
//  Module   : instruction_encoder
//  Brief    : Packs DK/S/RAW field sets into 16-bit words and streams them
//             through a small FIFO into instruction memory from a base address.
//             Optional macro ENC_CHK_EN also rejects S-type with op_s > SHIFT_OP_MAX.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_encoder #(
    parameter int         ADDR_W       = 8,
    parameter int         MEM_DEPTH    = 256,
    parameter int         FIFO_DEPTH   = 2,
    parameter logic [3:0] SHIFT_OP_MAX = 4'h7
) (
    input wire                   clk,
    input wire                   reset,
    instruction_encoder_if.slave bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [PTR_W:0]    c_FULL      = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef ENC_CHK_EN
    localparam logic [4:0] c_OP_S_LIMIT = {1'b0, SHIFT_OP_MAX};
`else
    // Limit saturates at 4'hF so every op_s value passes.
    localparam logic [4:0] c_OP_S_LIMIT = 5'h0F | {1'b0, SHIFT_OP_MAX};
`endif

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [15:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_acc_addr;
    logic              r_acc_end;
    logic [ADDR_W-1:0] r_last_addr;
    logic [15:0]       r_last_wdata;
    logic              r_done;
    logic              r_err;

    logic [15:0]       w_word;
    logic              w_reject;
    logic              w_busy;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic              w_mem_we;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL);
    assign w_mem_we = !w_empty;
    assign w_accept = bus.in_valid & w_in_ready;
    assign w_push   = w_accept & !w_reject;
    assign w_pop    = w_mem_we & bus.mem_ready;

    // Field packing; fmt 3 is reserved and always rejected.
    always_comb begin
        w_word   = 16'h0000;
        w_reject = 1'b0;
        case (bus.fmt)
            2'd0: w_word = {bus.op_dk, bus.arp, bus.dk};
            2'd1: begin
                w_word   = {bus.op_s, bus.s, bus.arp, bus.dk};
                w_reject = ({1'b0, bus.op_s} > c_OP_S_LIMIT);
            end
            2'd2:    w_word   = bus.all;
            default: w_reject = 1'b1;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start) w_state_nxt = c_RUN;
            end
            c_RUN: begin
                if (bus.finish || r_acc_end)
                    w_state_nxt = (w_empty && !w_push) ? c_IDLE : c_DRAIN;
            end
            c_DRAIN: begin
                if (w_empty) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy     = (r_state != c_IDLE);
        w_in_ready = (r_state == c_RUN) && !w_full && !r_acc_end;
    end

    // Storage has no reset: occupancy is governed entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Address tracking: acceptance side never wraps past the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_addr    <= '0;
            r_acc_addr   <= '0;
            r_acc_end    <= 1'b0;
            r_last_addr  <= '0;
            r_last_wdata <= 16'h0000;
        end else begin
            if ((r_state == c_IDLE) && bus.start) begin
                r_wr_addr  <= bus.base_addr;
                r_acc_addr <= bus.base_addr;
                r_acc_end  <= 1'b0;
            end else begin
                if (w_pop) r_wr_addr <= r_wr_addr + 1'b1;
                if (w_push) begin
                    if (r_acc_addr == c_LAST_ADDR) r_acc_end  <= 1'b1;
                    else                           r_acc_addr <= r_acc_addr + 1'b1;
                end
            end
            if (w_pop) begin
                r_last_addr  <= r_wr_addr;
                r_last_wdata <= r_fifo[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= (r_state != c_IDLE) && (w_state_nxt == c_IDLE);
            r_err  <= w_accept & w_reject;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_we ? r_wr_addr : r_last_addr;
    assign bus.mem_wdata = w_mem_we ? r_fifo[r_rd_ptr] : r_last_wdata;

endmodule

`default_nettype wire

// File: tb/tb_instruction_encoder.sv
// ============================================================================
//  Module   : tb_instruction_encoder
//  Brief    : Directed and random stimulus against a queue-based reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_encoder;

    localparam int ADDR_W     = 8;
    localparam int MEM_DEPTH  = 256;
    localparam int FIFO_DEPTH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    instruction_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_encoder #(
        .ADDR_W      (ADDR_W),
        .MEM_DEPTH   (MEM_DEPTH),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SHIFT_OP_MAX(4'h7)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: program state, queue of pending words, written-word log.
    logic        m_busy = 1'b0, m_drain = 1'b0, m_end = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic [15:0] m_q[$];
    logic [7:0]  m_wr = 8'h00, m_last_addr = 8'h00;
    logic [15:0] m_last_data = 16'h0000;
    int          m_acc = 0;
    logic [23:0] wlog[$];

    function automatic logic [15:0] enc_word(input logic [1:0] f, input logic [7:0] opd,
                                             input logic [3:0] ops, input logic [3:0] sv,
                                             input logic a, input logic [6:0] d,
                                             input logic [15:0] raw);
        int v;
        v = 0;
        if (f == 2'd0)      v = int'(opd) * 256 + int'(a) * 128 + int'(d);
        else if (f == 2'd1) v = int'(ops) * 4096 + int'(sv) * 256 + int'(a) * 128 + int'(d);
        else                v = int'(raw);
        return 16'(v);
    endfunction

    function automatic logic is_rejected(input logic [1:0] f, input logic [3:0] ops);
`ifdef ENC_CHK_EN
        return (f == 2'd3) || (f == 2'd1 && int'(ops) > 7);
`else
        return (f == 2'd3) || (ops != ops);
`endif
    endfunction

    always @(negedge clk) begin
        logic exp_rdy, exp_we, acc, rej, push, pop, was_empty;
        exp_rdy = m_busy && !m_drain && (m_q.size() < FIFO_DEPTH) && !m_end;
        exp_we  = (m_q.size() > 0);
        check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check_eq("mem_we",   32'(bus.mem_we),   32'(exp_we));
        check_eq("mem_addr", 32'(bus.mem_addr), 32'(exp_we ? m_wr : m_last_addr));
        check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(exp_we ? m_q[0] : m_last_data));
        check_eq("busy", 32'(bus.busy), 32'(m_busy));
        check_eq("done", 32'(bus.done), 32'(m_done));
        check_eq("err",  32'(bus.err),  32'(m_err));
        if (bus.mem_we && bus.mem_ready) wlog.push_back({bus.mem_addr, bus.mem_wdata});

        if (reset) begin
            m_busy = 0; m_drain = 0; m_end = 0; m_done = 0; m_err = 0;
            m_q.delete(); m_wr = 0; m_last_addr = 0; m_last_data = 0; m_acc = 0;
        end else begin
            acc       = bus.in_valid && exp_rdy;
            rej       = is_rejected(bus.fmt, bus.op_s);
            push      = acc && !rej;
            pop       = exp_we && bus.mem_ready;
            was_empty = (m_q.size() == 0);
            m_err     = acc && rej;
            m_done    = 0;
            if (pop) begin
                m_last_addr = m_wr;
                m_last_data = m_q.pop_front();
                m_wr++;
            end
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy = 1; m_drain = 0; m_end = 0;
                    m_wr = bus.base_addr; m_acc = int'(bus.base_addr);
                end
            end else if (!m_drain) begin
                if (bus.finish || m_end) begin
                    if (was_empty && !push) begin m_busy = 0; m_done = 1; end
                    else m_drain = 1;
                end
            end else if (was_empty) begin
                m_busy = 0; m_drain = 0; m_done = 1;
            end
            if (push) begin
                m_q.push_back(enc_word(bus.fmt, bus.op_dk, bus.op_s, bus.s, bus.arp, bus.dk, bus.all));
                if (m_acc == MEM_DEPTH - 1) m_end = 1;
                m_acc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dk(input logic [7:0] op, input logic a, input logic [6:0] d);
        bus.fmt = 2'd0; bus.op_dk = op; bus.arp = a; bus.dk = d; bus.in_valid = 1'b1;
    endtask

    task automatic set_s(input logic [3:0] op, input logic [3:0] sv, input logic a, input logic [6:0] d);
        bus.fmt = 2'd1; bus.op_s = op; bus.s = sv; bus.arp = a; bus.dk = d; bus.in_valid = 1'b1;
    endtask

    task automatic set_fmt(input logic [1:0] f, input logic [15:0] raw);
        bus.fmt = f; bus.all = raw; bus.in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        logic r;
        for (int i = 0; i < 200; i++) begin
            r = bus.in_ready;
            step();
            if (r) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        check_eq("accept_timeout", 32'd1, 32'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic begin_prog(input logic [7:0] base);
        wlog.delete();
        bus.base_addr = base; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic end_prog();
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!bus.busy) return;
            step();
        end
        check_eq("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_log(input string tag, input int idx, input logic [7:0] a, input logic [15:0] d);
        if (idx < wlog.size()) check_eq(tag, 32'(wlog[idx]), 32'({a, d}));
        else                   check_eq(tag, 32'hFFFF_FFFF, 32'({a, d}));
    endtask

    initial begin
        bus.start = 0; bus.base_addr = 0; bus.finish = 0; bus.in_valid = 0; bus.fmt = 0;
        bus.op_dk = 0; bus.op_s = 0; bus.s = 0; bus.arp = 0; bus.dk = 0; bus.all = 0;
        bus.mem_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Single DK word.
        begin_prog(8'h10);
        set_dk(8'h38, 1'b1, 7'h05); wait_accept();
        end_prog();
        check_eq("t1_count", 32'(wlog.size()), 32'd1);
        check_log("t1_word", 0, 8'h10, 16'h3885);

        // S-type followed by RAW.
        begin_prog(8'h20);
        set_s(4'h2, 4'h4, 1'b0, 7'h10); wait_accept();
        set_fmt(2'd2, 16'hBEEF);        wait_accept();
        end_prog();
        check_log("t2_w0", 0, 8'h20, 16'h2410);
        check_log("t2_w1", 1, 8'h21, 16'hBEEF);

        // Stalled memory port fills the FIFO.
        bus.mem_ready = 1'b0;
        begin_prog(8'h30);
        set_fmt(2'd2, 16'h1111); wait_accept();
        set_fmt(2'd2, 16'h2222); wait_accept();
        set_fmt(2'd2, 16'h3333);
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_stall_ready", 32'(bus.in_ready), 32'd0);
            step();
        end
        bus.mem_ready = 1'b1;
        wait_accept();
        end_prog();
        check_eq("t3_count", 32'(wlog.size()), 32'd3);
        check_log("t3_w0", 0, 8'h30, 16'h1111);
        check_log("t3_w1", 1, 8'h31, 16'h2222);
        check_log("t3_w2", 2, 8'h32, 16'h3333);

        // Top of memory: third set never accepted, program ends by itself.
        begin_prog(8'(MEM_DEPTH - 2));
        set_fmt(2'd2, 16'hA001); wait_accept();
        set_fmt(2'd2, 16'hA002); wait_accept();
        check_eq("t4_ready_end", 32'(bus.in_ready), 32'd0);
        set_fmt(2'd2, 16'hA003);
        for (int i = 0; i < 50 && bus.busy; i++) step();
        check_eq("t4_idle", 32'(bus.busy), 32'd0);
        bus.in_valid = 1'b0;
        step();
        check_eq("t4_count", 32'(wlog.size()), 32'd2);
        check_log("t4_w0", 0, 8'(MEM_DEPTH - 2), 16'hA001);
        check_log("t4_w1", 1, 8'(MEM_DEPTH - 1), 16'hA002);

        // Rejected field sets mid-stream.
        begin_prog(8'h40);
        set_fmt(2'd2, 16'h0F0F); wait_accept();
        set_fmt(2'd3, 16'hDEAD); wait_accept();
        check_eq("t5_err", 32'(bus.err), 32'd1);
`ifdef ENC_CHK_EN
        set_s(4'h9, 4'h1, 1'b1, 7'h01); wait_accept();
        check_eq("t5_err_ops", 32'(bus.err), 32'd1);
`endif
        set_fmt(2'd2, 16'hF0F0); wait_accept();
        end_prog();
        check_eq("t5_count", 32'(wlog.size()), 32'd2);
        check_log("t5_w0", 0, 8'h40, 16'h0F0F);
        check_log("t5_w1", 1, 8'h41, 16'hF0F0);

        // Reset with buffered words and a stalled port.
        bus.mem_ready = 1'b0;
        begin_prog(8'h50);
        set_fmt(2'd2, 16'h5555); wait_accept();
        set_fmt(2'd2, 16'h6666); wait_accept();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t6_we", 32'(bus.mem_we), 32'd0);
        check_eq("t6_busy", 32'(bus.busy), 32'd0);
        bus.mem_ready = 1'b1;
        step();
        check_eq("t6_done", 32'(bus.done), 32'd0);
        check_eq("t6_count", 32'(wlog.size()), 32'd0);

        // Random programs, some near the top of memory.
        for (int p = 0; p < 12; p++) begin
            begin_prog(($urandom_range(0, 2) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom));
            for (int c = 0; c < 40; c++) begin
                bus.fmt = 2'($urandom); bus.op_dk = 8'($urandom); bus.op_s = 4'($urandom);
                bus.s = 4'($urandom); bus.arp = 1'($urandom); bus.dk = 7'($urandom);
                bus.all = 16'($urandom);
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.mem_ready = ($urandom_range(0, 2) != 0);
                bus.start     = ($urandom_range(0, 15) == 0);
                bus.finish    = ($urandom_range(0, 24) == 0);
                step();
            end
            bus.in_valid = 1'b0; bus.start = 1'b0; bus.mem_ready = 1'b1;
            end_prog();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
